// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage pipeline with one non-pipelined long-latency unit beside E.
// Define HAZARD_LONGOP_EN to build the long-op scoreboard; without it only M/W forwarding, load-use and branch flush remain.
module hazard_unit_mc #(
    parameter int REG_AW   = 5,
    parameter int LONG_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic              RegWriteE,
    input  logic              RegWriteD,
    input  logic              ResultSrcE0,
    input  logic              LongOpE,
    input  logic              LongOpD,
    input  logic              PCSrcE,
    input  logic              CacheStall,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              LongBusy,
    output logic              LongWbEn,
    output logic [REG_AW-1:0] LongWbRd
);

    logic              long_busy_st;
    logic              long_done_st;
    logic [REG_AW-1:0] wb_rd;
    logic              long_use;
    logic              long_raw;
    logic              long_struct;
    logic              lw_stall;
    logic              hz;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

`ifdef HAZARD_LONGOP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LONG_LAT - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic [REG_AW-1:0] wb_rd_next;
    logic              issue;

    assign issue = LongOpE & RegWriteE & (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            wb_rd <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            wb_rd <= wb_rd_next;
        end
    end

    // DONE never accepts an issue: the D-stage structural stall keeps a second long op out of E.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wb_rd_next = wb_rd;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                    wb_rd_next = RdE;
                end
            end
            BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign long_busy_st = (state == BUSY);
    assign long_done_st = (state == DONE);

    assign long_use    = LongOpE & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
    // The RdD term blocks a younger write to the same register (WAW).
    assign long_raw    = long_busy_st & (wb_rd != '0) &
                         ((Rs1D == wb_rd) | (Rs2D == wb_rd) | (RegWriteD & (RdD == wb_rd)));
    assign long_struct = LongOpD & (long_busy_st | LongOpE);

    assign LongBusy = (state != IDLE);
    assign LongWbEn = rst & long_done_st;
    assign LongWbRd = wb_rd;
`else
    logic unused_long;

    assign unused_long  = ^{clk, LongOpE, LongOpD, RegWriteE, RegWriteD, RdD};
    assign long_busy_st = 1'b0;
    assign long_done_st = 1'b0;
    assign wb_rd        = '0;
    assign long_use     = 1'b0;
    assign long_raw     = 1'b0;
    assign long_struct  = 1'b0;
    assign LongBusy     = 1'b0;
    assign LongWbEn     = 1'b0;
    assign LongWbRd     = '0;
`endif

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w,
        input logic              done,
        input logic [REG_AW-1:0] rd_long
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != '0) && (rd_m == src))
            sel = 2'b10;
        else if (wr_w && (rd_w != '0) && (rd_w == src))
            sel = 2'b01;
        else if (done && (rd_long != '0) && (rd_long == src))
            sel = 2'b11;
        return sel;
    endfunction

    assign fwd_a = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW, long_done_st, wb_rd);
    assign fwd_b = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW, long_done_st, wb_rd);

    assign lw_stall = ResultSrcE0 & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
    assign hz       = lw_stall | long_use | long_raw | long_struct;

    // Every combinational output is forced low while reset is held.
    assign ForwardAE = rst ? fwd_a : 2'b00;
    assign ForwardBE = rst ? fwd_b : 2'b00;
    assign StallD    = rst & hz;
    assign StallF    = rst & (hz | CacheStall);
    assign FlushE    = rst & (hz | PCSrcE);
    assign FlushD    = rst & PCSrcE;

endmodule
